accum_mem_ctrl: RTL and testbench

ACCUM_MEM_CTRL -- requirements
Module: accum_mem_ctrl

---
 rtl/accum_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_accum_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/accum_mem_ctrl.sv
// Accumulator memory controller: collects skewed systolic-array partial sums into
// per-column banks (overwrite or accumulate) and serves host reads. Define ACCUM_SAT_EN
// for saturating accumulation; the default build wraps.
module accum_mem_ctrl #(
    parameter int SYS_COL    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 1024,
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
    localparam int ADDR_WIDTH = $clog2(ACCUM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] num_row,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  accum,
    input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
    input  logic [SYS_COL-1:0]    en_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data [0:SYS_COL-1],
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = ((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] num_row_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  accum_q;
    logic [DATA_WIDTH-1:0] cnt     [SYS_COL];
    logic [PSUM_WIDTH-1:0] bank    [SYS_COL][ACCUM_SIZE];
    logic [SYS_COL-1:0]    wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr [SYS_COL];
    logic [PSUM_WIDTH-1:0] wr_data [SYS_COL];
    logic                  all_full;
    logic                  overflow_hit;

    // Two's-complement add; optionally clamps to the signed range on overflow.
    function automatic logic [PSUM_WIDTH-1:0] acc_add(input logic [PSUM_WIDTH-1:0] a,
                                                      input logic [PSUM_WIDTH-1:0] b);
        logic [PSUM_WIDTH-1:0] s;
        s = a + b;
`ifdef ACCUM_SAT_EN
        if ((a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1])) begin
            s = a[PSUM_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (all_full) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COLLECT);
        done = (state == DONE);
    end

    // Per-column write decode; the read half of the read-modify-write is combinational
    // so the accumulated value commits on the same edge.
    always_comb begin
        all_full     = 1'b1;
        overflow_hit = 1'b0;
        for (int c = 0; c < SYS_COL; c++) begin
            all_full   = all_full & (cnt[c] == num_row_q);
            wr_en[c]   = (state == COLLECT) && en_in[c] && (cnt[c] < num_row_q) && !rst;
            if ((state == COLLECT) && en_in[c] && (cnt[c] >= num_row_q)) begin
                overflow_hit = 1'b1;
            end
            wr_addr[c] = ADDR_WIDTH'((CW'(base_q) + CW'(cnt[c])) % CW'(ACCUM_SIZE));
            wr_data[c] = accum_q ? acc_add(bank[c][wr_addr[c]], psum_in[c]) : psum_in[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_row_q <= '0;
            base_q    <= '0;
            accum_q   <= 1'b0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            for (int c = 0; c < SYS_COL; c++) begin
                cnt[c]     <= '0;
                rd_data[c] <= '0;
            end
        end else begin
            if ((state == IDLE) && start) begin
                num_row_q <= num_row;
                base_q    <= base_addr;
                accum_q   <= accum;
                overflow  <= 1'b0;
                for (int c = 0; c < SYS_COL; c++) begin
                    cnt[c] <= '0;
                end
            end else begin
                for (int c = 0; c < SYS_COL; c++) begin
                    if (wr_en[c]) begin
                        cnt[c] <= cnt[c] + 1'b1;
                    end
                end
                if (overflow_hit) begin
                    overflow <= 1'b1;
                end
            end

            // Reads sample the array before any same-edge write lands.
            rd_valid <= 1'b0;
            if (rd_en && (state != COLLECT)) begin
                rd_valid <= 1'b1;
                for (int c = 0; c < SYS_COL; c++) begin
                    rd_data[c] <= bank[c][rd_addr];
                end
            end
        end
    end

    // Bank storage is deliberately left out of reset so an aborted pass keeps earlier rows.
    always_ff @(posedge clk) begin
        for (int c = 0; c < SYS_COL; c++) begin
            if (wr_en[c]) begin
                bank[c][wr_addr[c]] <= wr_data[c];
            end
        end
    end

endmodule

// File: tb/tb_accum_mem_ctrl.sv
// Directed self-checking bench for accum_mem_ctrl (default parameters).
// Expected saturation results follow ACCUM_SAT_EN when it is defined.
module tb_accum_mem_ctrl;

    localparam int SYS_COL = 4;
    localparam int DW      = 16;
    localparam int PW      = 32;
    localparam int AW      = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] num_row;
    logic [AW-1:0] base_addr;
    logic          accum;
    logic [PW-1:0] psum_in [0:SYS_COL-1];
    logic [SYS_COL-1:0] en_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data [0:SYS_COL-1];
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] sat_exp;

    accum_mem_ctrl #(
        .SYS_COL(SYS_COL),
        .DATA_WIDTH(DW),
        .ACCUM_SIZE(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_row(num_row),
        .base_addr(base_addr),
        .accum(accum),
        .psum_in(psum_in),
        .en_in(en_in),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stimulus value for column c, row r: 0 = 10*c+r, 1 = max positive, 2 = one.
    function automatic logic [PW-1:0] data_val(input int mode, input int c, input int r);
        case (mode)
            0:       return PW'(10 * c + r);
            1:       return 32'h7FFF_FFFF;
            default: return 32'h0000_0001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [PW-1:0] actual,
                               input logic [PW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Launch a pass and drive skewed valids; extra0 gives column 0 one surplus pulse.
    task automatic applyStimulus(input int base, input int nrow, input int acc,
                                 input int mode, input int extra0);
        start     = 1'b1;
        num_row   = DW'(nrow);
        base_addr = AW'(base);
        accum     = acc[0];
        tick();
        start = 1'b0;
        checkOutput("busy_in_collect", {31'b0, busy}, 32'd1);
        for (int k = 0; k < nrow + SYS_COL - 1; k++) begin
            for (int c = 0; c < SYS_COL; c++) begin
                int hi;
                hi = c + nrow + (((c == 0) && (extra0 != 0)) ? 1 : 0);
                en_in[c]   = (k >= c) && (k < hi);
                psum_in[c] = data_val(mode, c, k - c);
            end
            tick();
        end
        en_in = '0;
    endtask

    task automatic readRow(input int addr);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
        checkOutput($sformatf("rd_valid_a%0d", addr), {31'b0, rd_valid}, 32'd1);
    endtask

    task automatic finishPass(input string tag, input logic exp_ovf);
        tick();
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
        checkOutput({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
        tick();
        checkOutput({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_row = '0; base_addr = '0; accum = 1'b0;
        en_in = '0; rd_en = 1'b0; rd_addr = '0;
        for (int c = 0; c < SYS_COL; c++) psum_in[c] = '0;
        tick();
        tick();
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        checkOutput("rst_rd_data0", rd_data[0], 32'd0);
        rst = 1'b0;
        tick();

        // Overwrite pass at base 0
        applyStimulus(0, 4, 0, 0, 0);
        finishPass("p1", 1'b0);
        for (int r = 0; r < 4; r++) begin
            readRow(r);
            for (int c = 0; c < SYS_COL; c++)
                checkOutput($sformatf("p1_c%0d_r%0d", c, r), rd_data[c], data_val(0, c, r));
        end
        tick();
        checkOutput("rd_valid_drop", {31'b0, rd_valid}, 32'd0);

        // Accumulating pass over the same rows doubles them
        applyStimulus(0, 4, 1, 0, 0);
        finishPass("p2", 1'b0);
        for (int r = 0; r < 4; r++) begin
            readRow(r);
            for (int c = 0; c < SYS_COL; c++)
                checkOutput($sformatf("p2_c%0d_r%0d", c, r), rd_data[c], 2 * data_val(0, c, r));
        end

        // Address wrap from 1022
        applyStimulus(1022, 4, 0, 0, 0);
        finishPass("wrap", 1'b0);
        readRow(0);
        for (int c = 0; c < SYS_COL; c++)
            checkOutput($sformatf("wrap_a0_c%0d", c), rd_data[c], data_val(0, c, 2));
        readRow(1023);
        for (int c = 0; c < SYS_COL; c++)
            checkOutput($sformatf("wrap_a1023_c%0d", c), rd_data[c], data_val(0, c, 1));

        // Surplus pulse on column 0 raises sticky overflow
        applyStimulus(100, 4, 0, 0, 1);
        finishPass("ovf", 1'b1);
        tick();
        checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);
        readRow(103);
        checkOutput("ovf_c0_r3", rd_data[0], data_val(0, 0, 3));

        // Zero-row pass: straight through, overflow cleared by start
        start = 1'b1; num_row = '0; base_addr = AW'(500); accum = 1'b0;
        tick();
        start = 1'b0;
        checkOutput("nr0_busy", {31'b0, busy}, 32'd1);
        checkOutput("nr0_ovf_clear", {31'b0, overflow}, 32'd0);
        tick();
        checkOutput("nr0_done", {31'b0, done}, 32'd1);
        tick();
        checkOutput("nr0_done_drop", {31'b0, done}, 32'd0);

        // Signed-max plus one
`ifdef ACCUM_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_0000;
`endif
        applyStimulus(200, 1, 0, 1, 0);
        finishPass("satw", 1'b0);
        applyStimulus(200, 1, 1, 2, 0);
        finishPass("sata", 1'b0);
        readRow(200);
        for (int c = 0; c < SYS_COL; c++)
            checkOutput($sformatf("sat_c%0d", c), rd_data[c], sat_exp);

        // Reset after two of four rows; a read during COLLECT is ignored
        start = 1'b1; num_row = DW'(4); base_addr = AW'(300); accum = 1'b0;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            en_in = '1;
            for (int c = 0; c < SYS_COL; c++) psum_in[c] = data_val(0, c, r);
            if (r == 1) begin
                rd_en = 1'b1;
                rd_addr = '0;
            end
            tick();
        end
        en_in = '0;
        rd_en = 1'b0;
        checkOutput("collect_rd_valid", {31'b0, rd_valid}, 32'd0);
        checkOutput("collect_rd_held", rd_data[1], sat_exp);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_rd_data", rd_data[1], 32'd0);
        tick();
        checkOutput("abort_no_done", {31'b0, done}, 32'd0);
        for (int r = 0; r < 2; r++) begin
            readRow(300 + r);
            for (int c = 0; c < SYS_COL; c++)
                checkOutput($sformatf("abort_c%0d_r%0d", c, r), rd_data[c], data_val(0, c, r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
